// File: rtl/dp_exec_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dp_exec_ctrl                                                 |
// | Description : Data-processing execute controller. Sequences RF read, ALU   |
// |               execute and write-back, and owns the CNZV flags. Define the  |
// |               macro DP_COND_EXEC_EN to enable conditional execution.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dp_exec_ctrl #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst,
  input  logic                  in_Valid,
  output logic                  out_Ready,
  input  logic [3:0]            in_Cond,
  input  logic [3:0]            in_Opcode,
  input  logic                  in_SetFlags,
  input  logic [3:0]            in_Rd,
  input  logic [3:0]            in_RnSel,
  input  logic [WORD_WIDTH-1:0] in_Op2,
  input  logic                  in_ShCarry,
  output logic [3:0]            out_RfAddr,
  input  logic [WORD_WIDTH-1:0] in_RfData,
  output logic [WORD_WIDTH-1:0] out_AluRn,
  output logic [WORD_WIDTH-1:0] out_AluOp2,
  output logic                  out_AluCarry,
  output logic [3:0]            out_AluOpcode,
  input  logic [WORD_WIDTH-1:0] in_AluY,
  input  logic [3:0]            in_AluCNZV,
  output logic                  out_WbEn,
  output logic [3:0]            out_WbAddr,
  output logic [WORD_WIDTH-1:0] out_WbData,
  output logic [3:0]            out_CNZV,
  output logic                  out_Done,
  output logic                  out_Skipped
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]            r_opcode;
  logic [3:0]            r_rd;
  logic [3:0]            r_rn_sel;
  logic                  r_set_flags;
  logic                  r_sh_carry;
  logic [WORD_WIDTH-1:0] r_op1;
  logic [WORD_WIDTH-1:0] r_op2;
  logic [WORD_WIDTH-1:0] r_y;
  logic [3:0]            r_alu_cnzv;
  logic [3:0]            r_cnzv;

  logic w_accept;
  logic w_cond_pass;
  logic w_skip;
  logic w_is_test;
  logic w_is_arith;
  logic w_wb_active;
  logic w_flag_upd;

`ifdef DP_COND_EXEC_EN
  logic r_skip;

  // Flags are [3]=C [2]=N [1]=Z [0]=V.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic c, n, z, v;
    c = f[3];
    n = f[2];
    z = f[1];
    v = f[0];
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = ~c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = c & ~z;
      4'h9:    cond_pass = ~c | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign w_cond_pass = cond_pass(in_Cond, r_cnzv);
  assign w_skip      = r_skip;
`else
  logic w_unused_cond;

  assign w_unused_cond = ^in_Cond;
  assign w_cond_pass   = 1'b1;
  assign w_skip        = 1'b0;
`endif

  assign out_Ready   = (r_state == S_IDLE) & ~in_Rst;
  assign w_accept    = in_Valid & out_Ready;
  assign w_is_test   = (r_opcode[3:2] == 2'b10);
  assign w_is_arith  = ((r_opcode >= 4'h2) && (r_opcode <= 4'h7)) ||
                       (r_opcode == 4'hA) || (r_opcode == 4'hB);
  assign w_wb_active = (r_state == S_WB) & ~w_skip;
  assign w_flag_upd  = w_wb_active & (r_set_flags | w_is_test);
  assign out_CNZV    = r_cnzv;

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    out_RfAddr    = 4'd0;
    out_AluRn     = '0;
    out_AluOp2    = '0;
    out_AluCarry  = 1'b0;
    out_AluOpcode = 4'd0;
    out_WbEn      = 1'b0;
    out_WbAddr    = 4'd0;
    out_WbData    = '0;
    out_Done      = 1'b0;
    out_Skipped   = 1'b0;

    if (r_state != S_IDLE) begin
      out_RfAddr    = r_rn_sel;
      out_AluRn     = r_op1;
      out_AluOp2    = r_op2;
      out_AluCarry  = w_is_arith ? r_cnzv[3] : r_sh_carry;
      out_AluOpcode = r_opcode;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_cond_pass ? S_READ : S_WB;
        end
      end
      S_READ: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        // RF data arrives this cycle; feed it straight to the ALU.
        out_AluRn   = in_RfData;
        w_state_nxt = S_WB;
      end
      S_WB: begin
        out_Done    = 1'b1;
        out_Skipped = w_skip;
        if (w_wb_active) begin
          out_WbEn   = ~w_is_test;
          out_WbAddr = r_rd;
          out_WbData = r_y;
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      r_opcode    <= 4'd0;
      r_rd        <= 4'd0;
      r_rn_sel    <= 4'd0;
      r_set_flags <= 1'b0;
      r_sh_carry  <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_y         <= '0;
      r_alu_cnzv  <= 4'd0;
      r_cnzv      <= 4'd0;
`ifdef DP_COND_EXEC_EN
      r_skip      <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_opcode    <= in_Opcode;
        r_rd        <= in_Rd;
        r_rn_sel    <= in_RnSel;
        r_set_flags <= in_SetFlags;
        r_sh_carry  <= in_ShCarry;
        r_op2       <= in_Op2;
        r_op1       <= '0;
`ifdef DP_COND_EXEC_EN
        r_skip      <= ~w_cond_pass;
`endif
      end
      if (r_state == S_EXEC) begin
        r_op1      <= in_RfData;
        r_y        <= in_AluY;
        r_alu_cnzv <= in_AluCNZV;
      end
      // Logical ops leave V untouched.
      if (w_flag_upd) begin
        r_cnzv <= w_is_arith ? r_alu_cnzv : {r_alu_cnzv[3:1], r_cnzv[0]};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_exec_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dp_exec_ctrl                                              |
// | Description : Directed bench for dp_exec_ctrl with RF and ALU models.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dp_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [3:0]  cond = 4'hE;
  logic [3:0]  opcode = 4'h0;
  logic        set_flags = 1'b0;
  logic [3:0]  rd = 4'h0;
  logic [3:0]  rn_sel = 4'h0;
  logic [31:0] op2 = 32'h0;
  logic        sh_carry = 1'b0;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] alu_rn, alu_op2, alu_y;
  logic        alu_c;
  logic [3:0]  alu_opc, alu_cnzv;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  cnzv;
  logic        done, skipped;

  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = 4'h0;
  logic [31:0] pl_data = 32'h0;
  logic [31:0] rf [16];

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0, done_cnt = 0, wb_cnt = 0, skip_cnt = 0;
  int a0, d0, w0, s0;

  always #5 clk = ~clk;

  dp_exec_ctrl #(.WORD_WIDTH(32)) dut (
    .in_Clk(clk), .in_Rst(rst), .in_Valid(valid), .out_Ready(ready),
    .in_Cond(cond), .in_Opcode(opcode), .in_SetFlags(set_flags), .in_Rd(rd),
    .in_RnSel(rn_sel), .in_Op2(op2), .in_ShCarry(sh_carry),
    .out_RfAddr(rf_addr), .in_RfData(rf_data),
    .out_AluRn(alu_rn), .out_AluOp2(alu_op2), .out_AluCarry(alu_c),
    .out_AluOpcode(alu_opc), .in_AluY(alu_y), .in_AluCNZV(alu_cnzv),
    .out_WbEn(wb_en), .out_WbAddr(wb_addr), .out_WbData(wb_data),
    .out_CNZV(cnzv), .out_Done(done), .out_Skipped(skipped)
  );

  // Register file: synchronous read, write from the DUT port or bench preload.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'h0;
      rf_data <= 32'h0;
    end else begin
      rf_data <= rf[rf_addr];
      if (wb_en) rf[wb_addr] <= wb_data;
      if (pl_en) rf[pl_addr] <= pl_data;
    end
  end

  always @(posedge clk) begin
    if (valid && ready) acc_cnt <= acc_cnt + 1;
    if (done)           done_cnt <= done_cnt + 1;
    if (wb_en)          wb_cnt <= wb_cnt + 1;
    if (skipped)        skip_cnt <= skip_cnt + 1;
  end

  // Combinational ALU model.
  logic [31:0] m_a, m_b;
  logic        m_cin, m_arith;
  logic [32:0] m_s;
  always_comb begin
    m_arith = 1'b1;
    m_a     = alu_rn;
    m_b     = alu_op2;
    m_cin   = 1'b0;
    case (alu_opc)
      4'h2, 4'hA: begin m_b = ~alu_op2; m_cin = 1'b1; end
      4'h3:       begin m_a = alu_op2; m_b = ~alu_rn; m_cin = 1'b1; end
      4'h4, 4'hB: m_cin = 1'b0;
      4'h5:       m_cin = alu_c;
      4'h6:       begin m_b = ~alu_op2; m_cin = alu_c; end
      4'h7:       begin m_a = alu_op2; m_b = ~alu_rn; m_cin = alu_c; end
      default:    m_arith = 1'b0;
    endcase
    m_s = {1'b0, m_a} + {1'b0, m_b} + {32'd0, m_cin};
    case (alu_opc)
      4'h0, 4'h8: alu_y = alu_rn & alu_op2;
      4'h1, 4'h9: alu_y = alu_rn ^ alu_op2;
      4'hC:       alu_y = alu_rn | alu_op2;
      4'hD:       alu_y = alu_op2;
      4'hE:       alu_y = alu_rn & ~alu_op2;
      4'hF:       alu_y = ~alu_op2;
      default:    alu_y = m_s[31:0];
    endcase
    alu_cnzv[3] = m_arith ? m_s[32] : alu_c;
    alu_cnzv[2] = alu_y[31];
    alu_cnzv[1] = (alu_y == 32'h0);
    alu_cnzv[0] = m_arith & (m_a[31] == m_b[31]) & (alu_y[31] != m_a[31]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Returns #1 after the accept edge; fields are then scrambled.
  task automatic issue(input logic [3:0] c, input logic [3:0] opc, input logic s,
                       input logic [3:0] d, input logic [3:0] n, input logic [31:0] o2,
                       input logic shc);
    @(negedge clk);
    valid = 1'b1; cond = c; opcode = opc; set_flags = s; rd = d; rn_sel = n;
    op2 = o2; sh_carry = shc;
    @(posedge clk); #1;
    valid = 1'b0; cond = ~c; opcode = ~opc; set_flags = ~s; rd = ~d; rn_sel = ~n;
    op2 = 32'hDEAD_BEEF; sh_carry = ~shc;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check("ready_in_reset", {31'd0, ready}, 32'd0);
    check("cnzv_in_reset", {28'd0, cnzv}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, ready}, 32'd1);
    check("done_after_rst", {31'd0, done}, 32'd0);
    check("wben_after_rst", {31'd0, wb_en}, 32'd0);

    // ADD R2 = R1(5) + 3, S=1
    preload(4'd1, 32'd5);
    issue(4'hE, 4'h4, 1'b1, 4'd2, 4'd1, 32'd3, 1'b0);
    check("add_read_rfaddr", {28'd0, rf_addr}, 32'd1);
    check("add_read_ready", {31'd0, ready}, 32'd0);
    check("add_read_done", {31'd0, done}, 32'd0);
    step();
    check("add_exec_rn", alu_rn, 32'd5);
    check("add_exec_op2", alu_op2, 32'd3);
    check("add_exec_opc", {28'd0, alu_opc}, 32'h4);
    check("add_exec_carry", {31'd0, alu_c}, 32'd0);
    check("add_exec_done", {31'd0, done}, 32'd0);
    step();
    check("add_wb_done", {31'd0, done}, 32'd1);
    check("add_wb_en", {31'd0, wb_en}, 32'd1);
    check("add_wb_addr", {28'd0, wb_addr}, 32'd2);
    check("add_wb_data", wb_data, 32'd8);
    check("add_wb_skipped", {31'd0, skipped}, 32'd0);
    step();
    check("add_idle_ready", {31'd0, ready}, 32'd1);
    check("add_idle_done", {31'd0, done}, 32'd0);
    check("add_cnzv", {28'd0, cnzv}, 32'b0000);
    check("add_rf2", rf[2], 32'd8);
    check("idle_alu_opc_zero", {28'd0, alu_opc}, 32'd0);

    // CMP R1(5), 5
    issue(4'hE, 4'hA, 1'b0, 4'd7, 4'd1, 32'd5, 1'b1);
    step();
    check("cmp_exec_carry", {31'd0, alu_c}, 32'd0);
    step();
    check("cmp_wb_done", {31'd0, done}, 32'd1);
    check("cmp_wb_en", {31'd0, wb_en}, 32'd0);
    step();
    check("cmp_cnzv", {28'd0, cnzv}, 32'b1010);
    check("cmp_rf7", rf[7], 32'd0);

    // MOVNE R4, 7 with Z=1
    issue(4'h1, 4'hD, 1'b0, 4'd4, 4'd0, 32'd7, 1'b0);
`ifdef DP_COND_EXEC_EN
    check("movne_done", {31'd0, done}, 32'd1);
    check("movne_skipped", {31'd0, skipped}, 32'd1);
    check("movne_wben", {31'd0, wb_en}, 32'd0);
    step();
    check("movne_ready", {31'd0, ready}, 32'd1);
    check("movne_rf4", rf[4], 32'd0);
`else
    check("movne_skipped", {31'd0, skipped}, 32'd0);
    step();
    step();
    check("movne_wb_data", wb_data, 32'd7);
    check("movne_wben", {31'd0, wb_en}, 32'd1);
    step();
    check("movne_rf4", rf[4], 32'd7);
`endif
    check("movne_cnzv", {28'd0, cnzv}, 32'b1010);

    // ADC R3 = R1(1) + 1 + C(1)
    preload(4'd1, 32'd1);
    issue(4'hE, 4'h5, 1'b0, 4'd3, 4'd1, 32'd1, 1'b0);
    step();
    check("adc_exec_carry", {31'd0, alu_c}, 32'd1);
    step();
    check("adc_wb_data", wb_data, 32'd3);
    step();
    check("adc_cnzv_held", {28'd0, cnzv}, 32'b1010);

    // ORR S=1 ShCarry=0, result 0
    issue(4'hE, 4'hC, 1'b1, 4'd10, 4'd0, 32'd0, 1'b0);
    step();
    check("orr_exec_carry", {31'd0, alu_c}, 32'd0);
    step();
    check("orr_wb_data", wb_data, 32'd0);
    step();
    check("orr_cnzv", {28'd0, cnzv}, 32'b0010);

    // ADD overflow sets V, then logical op keeps V
    preload(4'd5, 32'h7FFF_FFFF);
    issue(4'hE, 4'h4, 1'b1, 4'd6, 4'd5, 32'd1, 1'b0);
    repeat (3) step();
    check("ovf_cnzv", {28'd0, cnzv}, 32'b0101);
    check("ovf_rf6", rf[6], 32'h8000_0000);
    issue(4'hE, 4'hC, 1'b1, 4'd11, 4'd0, 32'd0, 1'b1);
    step();
    check("orr2_exec_carry", {31'd0, alu_c}, 32'd1);
    repeat (2) step();
    check("orr2_cnzv_vheld", {28'd0, cnzv}, 32'b1011);

    // Reset during EXEC
    issue(4'hE, 4'h4, 1'b1, 4'd8, 4'd1, 32'd1, 1'b0);
    step();
    w0 = wb_cnt; d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("rst_exec_cnzv", {28'd0, cnzv}, 32'd0);
    check("rst_exec_ready", {31'd0, ready}, 32'd0);
    check("rst_exec_aluopc", {28'd0, alu_opc}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'd0, ready}, 32'd1);
    repeat (4) step();
    check("rst_no_wb", wb_cnt - w0, 32'd0);
    check("rst_no_done", done_cnt - d0, 32'd0);
    check("rst_cnzv_after", {28'd0, cnzv}, 32'd0);

    // Throughput, passing instructions with Valid held high
    a0 = acc_cnt; d0 = done_cnt;
    @(negedge clk);
    valid = 1'b1; cond = 4'hE; opcode = 4'hD; set_flags = 1'b0; rd = 4'd9;
    rn_sel = 4'd0; op2 = 32'h55; sh_carry = 1'b0;
    repeat (12) @(negedge clk);
    valid = 1'b0;
    check("tput_pass_accepts", acc_cnt - a0, 32'd3);
    check("tput_pass_dones", done_cnt - d0, 32'd3);

    // Throughput, never-condition with Valid held high
    a0 = acc_cnt; w0 = wb_cnt; s0 = skip_cnt;
    valid = 1'b1; cond = 4'hF;
    repeat (8) @(negedge clk);
    valid = 1'b0;
`ifdef DP_COND_EXEC_EN
    check("tput_skip_accepts", acc_cnt - a0, 32'd4);
    check("tput_skip_skips", skip_cnt - s0, 32'd4);
    check("tput_skip_nowb", wb_cnt - w0, 32'd0);
`else
    check("tput_al_accepts", acc_cnt - a0, 32'd2);
    check("tput_al_skips", skip_cnt - s0, 32'd0);
    check("tput_al_wb", wb_cnt - w0, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
